// File: rtl/newhope_pkg.sv
// Shared NewHope ciphertext-transfer constants and types.
//   CT_C_BYTES / CT_H_BYTES : EncodePoly(U) and Compress(V'') byte counts
//   CT_CA_W / CT_HA_W       : c and h byte-address widths
//   ct_state_e              : transfer sequencer states
//   ct_slot_t               : read-pipeline slot {valid, byte index}
package newhope_pkg;

   localparam int unsigned CT_C_BYTES = 896;
   localparam int unsigned CT_H_BYTES = 192;
   localparam int unsigned CT_CA_W    = 10;
   localparam int unsigned CT_HA_W    = 8;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2,
      DONE  = 2'd3
   } ct_state_e;

   typedef struct packed {
      logic               v;
      logic [CT_CA_W-1:0] idx;
   } ct_slot_t;

endpackage

// File: rtl/ct_rd_pipe.sv
// LAT-stage {valid, index} delay line matching the encrypter read latency.
//   clk, rst : clock, asynchronous active-low clear
//   en       : shift enable (stages hold when low)
//   d        : slot entering with the address just presented
//   q        : slot whose data is on the source read port this cycle
module ct_rd_pipe
   import newhope_pkg::*;
#(
   parameter int unsigned LAT = 1
) (
   input  logic     clk,
   input  logic     rst,
   input  logic     en,
   input  ct_slot_t d,
   output ct_slot_t q
);

   ct_slot_t sr [LAT];

   // Shift register; stage 0 takes the issued slot
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < int'(LAT); i++) sr[i] <= '0;
      end else if (en) begin
         sr[0] <= d;
         for (int i = 1; i < int'(LAT); i++) sr[i] <= sr[i-1];
      end
   end

   assign q = sr[LAT-1];

endmodule

// File: rtl/ct_transfer.sv
// Copies one NewHope ciphertext from the encrypter byte read ports into the
// decrypter byte RAMs at one byte per clock.
//   clk, rst, en, start     : clock, async active-low reset, clock enable, go
//   busy, done              : transfer in progress, one-cycle completion pulse
//   baddr_hout/bdout_h      : encrypter Compress(V'') read address / data
//   baddr_cout/bdout_c      : encrypter EncodePoly(U) read address / data
//   bwe_h/baddr_h/bdi_h     : decrypter h write strobe / address / data
//   bwe_c/baddr_c/bdi_c     : decrypter c write strobe / address / data
module ct_transfer
   import newhope_pkg::*;
#(
   parameter int unsigned C_BYTES = CT_C_BYTES,
   parameter int unsigned H_BYTES = CT_H_BYTES,
   parameter int unsigned RD_LAT  = 1
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               en,
   input  logic               start,
   output logic               busy,
   output logic               done,
   output logic [CT_HA_W-1:0] baddr_hout,
   input  logic [7:0]         bdout_h,
   output logic [CT_CA_W-1:0] baddr_cout,
   input  logic [7:0]         bdout_c,
   output logic               bwe_h,
   output logic [CT_HA_W-1:0] baddr_h,
   output logic [7:0]         bdi_h,
   output logic               bwe_c,
   output logic [CT_CA_W-1:0] baddr_c,
   output logic [7:0]         bdi_c
);

   localparam logic [CT_CA_W-1:0] LAST_IDX   = CT_CA_W'(C_BYTES - 1);
   localparam logic [CT_CA_W-1:0] H_LIM      = CT_CA_W'(H_BYTES);
   localparam logic [CT_HA_W-1:0] H_LAST     = CT_HA_W'(H_BYTES - 1);
   localparam logic [2:0]         DRAIN_LAST = 3'(RD_LAT);

   ct_state_e          state;
   logic               iss_v;
   logic [2:0]         dcnt;
   logic [CT_CA_W-1:0] addr_inc;
   ct_slot_t           iss_slot;
   ct_slot_t           rd_out;

   // h source address parks on its last byte once the h range is exhausted
   function automatic logic [CT_HA_W-1:0] h_addr(input logic [CT_CA_W-1:0] a);
      return (a < H_LIM) ? a[CT_HA_W-1:0] : H_LAST;
   endfunction

   assign addr_inc = baddr_cout + CT_CA_W'(1);
   assign iss_slot = '{v: iss_v, idx: baddr_cout};

   // Sequencer: baddr_cout doubles as the read counter
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state      <= IDLE;
         busy       <= 1'b0;
         done       <= 1'b0;
         iss_v      <= 1'b0;
         dcnt       <= '0;
         baddr_cout <= '0;
         baddr_hout <= '0;
      end else if (!en) begin
         done <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  state      <= RUN;
                  busy       <= 1'b1;
                  iss_v      <= 1'b1;
                  baddr_cout <= '0;
                  baddr_hout <= '0;
               end
            end
            RUN: begin
               if (baddr_cout == LAST_IDX) begin
                  state <= DRAIN;
                  iss_v <= 1'b0;
                  dcnt  <= '0;
               end else begin
                  baddr_cout <= addr_inc;
                  baddr_hout <= h_addr(addr_inc);
               end
            end
            DRAIN: begin
               if (dcnt == DRAIN_LAST) begin
                  state <= DONE;
                  busy  <= 1'b0;
                  done  <= 1'b1;
               end else begin
                  dcnt <= dcnt + 3'd1;
               end
            end
            DONE: begin
               // A pulse swallowed by en=0 is re-issued before leaving
               if (done) state <= IDLE;
               else      done  <= 1'b1;
            end
            default: state <= IDLE;
         endcase
      end
   end

   ct_rd_pipe #(.LAT(RD_LAT)) u_pipe (
      .clk (clk),
      .rst (rst),
      .en  (en),
      .d   (iss_slot),
      .q   (rd_out)
   );

   // Write registers: capture source data as its slot emerges
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         bwe_c   <= 1'b0;
         baddr_c <= '0;
         bdi_c   <= '0;
         bwe_h   <= 1'b0;
         baddr_h <= '0;
         bdi_h   <= '0;
      end else if (!en) begin
         bwe_c <= 1'b0;
         bwe_h <= 1'b0;
      end else begin
         bwe_c <= rd_out.v;
         bwe_h <= rd_out.v && (rd_out.idx < H_LIM);
         if (rd_out.v) begin
            baddr_c <= rd_out.idx;
            bdi_c   <= bdout_c;
            baddr_h <= rd_out.idx[CT_HA_W-1:0];
            bdi_h   <= bdout_h;
         end
      end
   end

endmodule

// File: tb/tb_ct_transfer.sv
// Scoreboard bench for ct_transfer: one RD_LAT=1 and one RD_LAT=3 instance.
module tb_ct_transfer;

   localparam int NC = 896;
   localparam int NH = 192;
   localparam int SC_A = 0, SC_B = 1, SC_C = 2, SC_P = 3, SC_D = 4;

   typedef struct {
      int addr;
      int data;
   } exp_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst, en, start1, start3;
   logic       busy1, done1, bwe_h1, bwe_c1, busy3, done3, bwe_h3, bwe_c3;
   logic [7:0] baddr_hout1, bdout_h1, baddr_h1, bdi_h1, bdout_c1, bdi_c1;
   logic [7:0] baddr_hout3, bdout_h3, baddr_h3, bdi_h3, bdout_c3, bdi_c3;
   logic [9:0] baddr_cout1, baddr_c1, baddr_cout3, baddr_c3;

   ct_transfer #(.RD_LAT(1)) dut1 (
      .clk(clk), .rst(rst), .en(en), .start(start1), .busy(busy1), .done(done1),
      .baddr_hout(baddr_hout1), .bdout_h(bdout_h1), .baddr_cout(baddr_cout1),
      .bdout_c(bdout_c1), .bwe_h(bwe_h1), .baddr_h(baddr_h1), .bdi_h(bdi_h1),
      .bwe_c(bwe_c1), .baddr_c(baddr_c1), .bdi_c(bdi_c1));

   ct_transfer #(.RD_LAT(3)) dut3 (
      .clk(clk), .rst(rst), .en(en), .start(start3), .busy(busy3), .done(done3),
      .baddr_hout(baddr_hout3), .bdout_h(bdout_h3), .baddr_cout(baddr_cout3),
      .bdout_c(bdout_c3), .bwe_h(bwe_h3), .baddr_h(baddr_h3), .bdi_h(bdi_h3),
      .bwe_c(bwe_c3), .baddr_c(baddr_c3), .bdi_c(bdi_c3));

   // Encrypter read-port models, clock-enabled like the rest of the datapath
   logic [9:0] sc1 = '0;
   logic [7:0] sh1 = '0;
   logic [9:0] sc3 [3];
   logic [7:0] sh3 [3];
   always @(posedge clk) if (en) begin
      sc1    <= baddr_cout1;  sh1    <= baddr_hout1;
      sc3[0] <= baddr_cout3;  sh3[0] <= baddr_hout3;
      sc3[1] <= sc3[0];       sh3[1] <= sh3[0];
      sc3[2] <= sc3[1];       sh3[2] <= sh3[1];
   end
   assign bdout_c1 = sc1[7:0] ^ 8'hA5;
   assign bdout_h1 = sh1 ^ 8'h3C;
   assign bdout_c3 = sc3[2][7:0] ^ 8'hA5;
   assign bdout_h3 = sh3[2] ^ 8'h3C;

   int   n_tests = 0, n_fail = 0;
   int   cyc = 0, S = 0, S2 = 0;
   logic en_q = 1'b1;
   exp_t q1c[$], q1h[$], q3c[$], q3h[$];
   int   wc1, wh1, dn1, done_at1, first1;
   int   wc3, wh3, dn3, done_at3, first3;

   always @(posedge clk) begin
      cyc  <= cyc + 1;
      en_q <= en;
   end

   task automatic chk(input string nm, input longint act, input longint exp);
      n_tests++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   task automatic extra(input string nm, input int addr);
      n_tests++;
      n_fail++;
      $display("FAIL %s: unexpected write at addr %0d, scoreboard empty", nm, addr);
   endtask

   task automatic push(input bit inst3);
      exp_t e;
      for (int i = 0; i < NC; i++) begin
         e.addr = i; e.data = (i & 255) ^ 'hA5;
         if (inst3) q3c.push_back(e); else q1c.push_back(e);
      end
      for (int i = 0; i < NH; i++) begin
         e.addr = i; e.data = i ^ 'h3C;
         if (inst3) q3h.push_back(e); else q1h.push_back(e);
      end
   endtask

   // Monitor, RD_LAT=1 instance
   always @(negedge clk) begin : mon1
      exp_t e;
      if (rst) begin
         if (!en_q) chk("strobe_off1", 64'({bwe_c1, bwe_h1}), 0);
         if (bwe_c1) begin
            wc1++;
            if (first1 < 0) first1 = cyc;
            if (q1c.size() == 0) extra("c1", int'(baddr_c1));
            else begin
               e = q1c.pop_front();
               chk("c1_addr", 64'(baddr_c1), e.addr);
               chk("c1_data", 64'(bdi_c1), e.data);
            end
         end
         if (bwe_h1) begin
            wh1++;
            if (q1h.size() == 0) extra("h1", int'(baddr_h1));
            else begin
               e = q1h.pop_front();
               chk("h1_addr", 64'(baddr_h1), e.addr);
               chk("h1_data", 64'(bdi_h1), e.data);
            end
         end
         if (done1) begin dn1++; done_at1 = cyc; end
      end
   end

   // Monitor, RD_LAT=3 instance
   always @(negedge clk) begin : mon3
      exp_t e;
      if (rst) begin
         if (!en_q) chk("strobe_off3", 64'({bwe_c3, bwe_h3}), 0);
         if (bwe_c3) begin
            wc3++;
            if (first3 < 0) first3 = cyc;
            if (q3c.size() == 0) extra("c3", int'(baddr_c3));
            else begin
               e = q3c.pop_front();
               chk("c3_addr", 64'(baddr_c3), e.addr);
               chk("c3_data", 64'(bdi_c3), e.data);
            end
         end
         if (bwe_h3) begin
            wh3++;
            if (q3h.size() == 0) extra("h3", int'(baddr_h3));
            else begin
               e = q3h.pop_front();
               chk("h3_addr", 64'(baddr_h3), e.addr);
               chk("h3_data", 64'(bdi_h3), e.data);
            end
         end
         if (done3) begin dn3++; done_at3 = cyc; end
      end
   end

   function automatic longint outs1();
      return 64'({busy1, done1, bwe_c1, bwe_h1, baddr_hout1, baddr_cout1,
                  baddr_h1, bdi_h1, baddr_c1, bdi_c1});
   endfunction
   function automatic longint outs3();
      return 64'({busy3, done3, bwe_c3, bwe_h3, baddr_hout3, baddr_cout3,
                  baddr_h3, bdi_h3, baddr_c3, bdi_c3});
   endfunction

   // One transfer run; relative cycle 1 is the cycle after the start edge
   task automatic run(input int scen, input int ncyc);
      int rel;
      bit use3;
      use3 = (scen != SC_D);
      push(1'b0);
      if (use3) push(1'b1);
      wc1 = 0; wh1 = 0; dn1 = 0; done_at1 = -1; first1 = -1;
      wc3 = 0; wh3 = 0; dn3 = 0; done_at3 = -1; first3 = -1;
      @(negedge clk);
      start1 = 1'b1; start3 = use3;
      @(negedge clk);
      start1 = 1'b0; start3 = 1'b0;
      S = cyc;
      rel = 1;
      chk("busy_rise1", 64'(busy1), 1);
      if (use3) chk("busy_rise3", 64'(busy3), 1);
      while (rel <= ncyc) begin
         case (scen)
            SC_A: begin
               start1 = (rel == 100) || (rel == 899);
               start3 = (rel == 100) || (rel == 901);
               if (rel == 898) chk("busy_last1", 64'(busy1), 1);
               if (rel == 899) chk("busy_done1", 64'({busy1, done1}), 1);
               if (rel == 901) chk("busy_done3", 64'({busy3, done3}), 1);
            end
            SC_B: en = !(rel >= 300 && rel < 320);
            SC_C: if (rel == 503) begin
               rst = 1'b0;
               #1;
               chk("abort_outs1", outs1(), 0);
               chk("abort_outs3", outs3(), 0);
               q1c.delete(); q1h.delete(); q3c.delete(); q3h.delete();
               break;
            end
            SC_D: begin
               start1 = (rel == 900);
               if (rel == 901) begin S2 = cyc; push(1'b0); end
            end
            default: ;
         endcase
         @(negedge clk);
         rel++;
      end
      start1 = 1'b0; start3 = 1'b0; en = 1'b1;
   endtask

   task automatic post_check(input int dly);
      chk("first_wr1", 64'(first1 - S + 1), 3);
      chk("first_wr3", 64'(first3 - S + 1), 5);
      chk("done_cyc1", 64'(done_at1 - S + 1), 899 + dly);
      chk("done_cyc3", 64'(done_at3 - S + 1), 901 + dly);
      chk("done_n1", 64'(dn1), 1);
      chk("done_n3", 64'(dn3), 1);
      chk("c_writes1", 64'(wc1), NC);
      chk("h_writes1", 64'(wh1), NH);
      chk("c_writes3", 64'(wc3), NC);
      chk("h_writes3", 64'(wh3), NH);
      chk("left1", 64'(q1c.size() + q1h.size()), 0);
      chk("left3", 64'(q3c.size() + q3h.size()), 0);
      chk("idle_after", 64'({busy1, busy3}), 0);
   endtask

   initial begin
      rst = 1'b0; en = 1'b1; start1 = 1'b0; start3 = 1'b0;
      repeat (2) @(negedge clk);
      chk("rst_outs1", outs1(), 0);
      chk("rst_outs3", outs3(), 0);
      rst = 1'b1;
      repeat (2) @(negedge clk);
      chk("idle_busy", 64'({busy1, busy3}), 0);

      run(SC_A, 910);
      post_check(0);

      run(SC_B, 930);
      post_check(20);

      run(SC_C, 503);
      repeat (2) @(negedge clk);
      chk("abort_no_done", 64'(dn1 + dn3), 0);
      chk("abort_held", outs1() | outs3(), 0);
      rst = 1'b1;
      @(negedge clk);
      run(SC_P, 905);
      post_check(0);

      run(SC_D, 1805);
      chk("b2b_done_cyc", 64'(done_at1 - S2 + 1), 899);
      chk("b2b_done_n", 64'(dn1), 2);
      chk("b2b_c_writes", 64'(wc1), 2 * NC);
      chk("b2b_h_writes", 64'(wh1), 2 * NH);
      chk("b2b_left", 64'(q1c.size() + q1h.size()), 0);
      chk("b2b_idle", 64'(busy1), 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/ct_transfer.md
Name: ct_transfer

Overview:
- Sequencer that copies one NewHope ciphertext from the encrypter's byte output ports into the decrypter's byte input RAMs.
- Sources: Compress(V'') (H_BYTES bytes) and EncodePoly(U) (C_BYTES bytes).
- Sits between encrypter_pl (upstream) and decrypter_pl (downstream), replacing host-driven byte-by-byte copying.
- Throughput 1 byte/clk, tolerating a configurable source read latency.

Parameters:
- C_BYTES, 896, EncodePoly(U) byte count; also the transfer length.
- H_BYTES, 192, Compress(V'') byte count; must be <= C_BYTES.
- RD_LAT, 1, encrypter output read latency in clocks, from address to valid data; legal range 1..4.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- en  in  1  clock enable; low freezes all state.
- start  in  1  one-cycle request to begin a transfer.
- busy  out  1  high from the accepted start until done.
- done  out  1  one-cycle pulse after the last write.
- baddr_hout  out  8  encrypter Compress(V'') read address.
- bdout_h  in  8  encrypter Compress(V'') read data.
- baddr_cout  out  10  encrypter EncodePoly read address.
- bdout_c  in  8  encrypter EncodePoly read data.
- bwe_h  out  1  decrypter h write strobe.
- baddr_h  out  8  decrypter h write address.
- bdi_h  out  8  decrypter h write data.
- bwe_c  out  1  decrypter c write strobe.
- baddr_c  out  10  decrypter c write address.
- bdi_c  out  8  decrypter c write data.

Behaviour:
- Reset (rst=0, asynchronous): every output goes to 0, state goes to IDLE, counters and pipeline are cleared. An in-flight transfer is abandoned and no done pulse is produced.
- All outputs are registered. No combinational path from any input to any output.
- en=0: state, counters, pipeline and address outputs hold. bwe_h/bwe_c are forced to 0. done is held 0; a done due that cycle is emitted on the first en=1 cycle.
- States:
  - IDLE: start=1 and en=1 -> RUN; busy rises the next cycle; rd counter cleared to 0.
  - RUN: drives baddr_cout = rd counter, and baddr_hout = rd counter[7:0] while rd counter < H_BYTES, else holds H_BYTES-1. Counter increments each enabled cycle. After issuing C_BYTES-1 -> DRAIN.
  - DRAIN: no new addresses; waits RD_LAT+1 enabled cycles for the pipeline to empty -> DONE.
  - DONE: done=1 and busy=0 for one cycle -> IDLE.
- Read pipeline: an RD_LAT-deep shift register carries {valid, index}. The slot that emerges samples bdout_c/bdout_h that cycle.
- Write registers, loaded on the next edge:
  - bwe_c=1, baddr_c=index, bdi_c=bdout_c.
  - bwe_h=(index<H_BYTES), baddr_h=index[7:0], bdi_h=bdout_h.
- Each write strobe is high for exactly one cycle per byte. Strobes occur back-to-back during steady state.
- Timing: with start accepted at edge 0 and en held high, address i is presented in cycle i+1 and the write of byte i is visible in cycle i+RD_LAT+2. done is high in cycle C_BYTES+RD_LAT+2, which is 899 at the defaults.
- start while busy=1 is ignored and not queued. start in the DONE cycle is also ignored.
- Index counter is 10 bits and never wraps: the last address is C_BYTES-1 and there is no write past it.

Decomposition:
- newhope_pkg holds the constants CT_C_BYTES=896 and CT_H_BYTES=192, the address widths (10 for c, 8 for h), and the state encoding localparams IDLE/RUN/DRAIN/DONE.
- One sub-module, ct_rd_pipe: a parameterised RD_LAT-stage {valid, index} delay line with enable and asynchronous active-low clear.

Test Plan:
- Basic: source models return bdout_c = addr[7:0]^8'hA5 and bdout_h = addr[7:0]^8'h3C with RD_LAT=1; pulse start -> 896 c writes with correct data, 192 h writes (addresses 0..191) only, done in cycle 899, busy high from cycle 1 to 898.
- start pulsed at cycle 100 and again in the DONE cycle -> ignored; exactly one transfer, with write count still 896/192.
- en low for 20 cycles starting at byte 300 -> no strobes while low, no duplicate or skipped index, done delayed by exactly 20 cycles to cycle 919.
- rst asserted at byte 500 -> all outputs 0 immediately with no done. A fresh start after release performs a full 896-byte transfer starting at address 0.
- RD_LAT=3 build -> data alignment correct, first write in cycle 5, done in cycle 901.
- Back-to-back: start in the cycle after done -> the second transfer matches the first, with the same 899-cycle latency.
